servo_pwm_sched: RTL and testbench
==================================

# servo_pwm_sched

Frame scheduler and configuration controller for a bank of servo PWM channels. Generates the shared unit-interval tick (`pulse_ui`) and per-channel staggered start-of-frame strobes (`ch_sof`), so channel pulse edges are spread across the frame. Holds host-written pulse widths and enables in shadow registers and commits them atomically at a fixed point before each frame, so a channel never sees a mid-pulse change. Sits between the host register interface and the per-channel PWM generators.

## Interface
- `NUM_CH`, 8: number of channels, 1..16.
- `CLKS_PER_UI`, 100: clk cycles per unit interval (1 us at 100 MHz), ≥2.
- `FRAME_UI`, 20000: UIs per frame, ≤32767.
- `STAGGER_UI`, 250: UI offset between consecutive channel SOFs.
- `MIN_UI`, 500: lower clamp for nonzero widths.
- `MAX_UI`, 2500: upper clamp, ≤4095.
- Constraint: (NUM_CH-1)*STAGGER_UI + MAX_UI < FRAME_UI-1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: 1 = timebase runs; 0 = timebase held at start.
- `wr_en` in 1: width write strobe, one cycle.
- `wr_addr` in 4: channel index.
- `wr_data` in 12: pulse width in UI; 0 = no pulse.
- `en_wr` in 1: enable-mask write strobe.
- `en_data` in NUM_CH: channel enable mask.
- `pulse_ui` out 1: one-cycle UI tick.
- `ch_sof` out NUM_CH: per-channel one-cycle start-of-frame.
- `ch_en` out NUM_CH: committed enables.
- `ch_pulse_width_ui` out 12*NUM_CH: committed widths; channel i occupies [12i+11:12i].
- `wr_ack` out 1: write accepted, one cycle.
- `wr_err` out 1: write rejected (address ≥ NUM_CH), one cycle.
- `commit_stb` out 1: one-cycle pulse when shadows are copied to active.
- `frame_ui_cnt` out 15: current UI index in the frame.

## Operation
- Prescaler `presc` counts 0..CLKS_PER_UI-1 while `run`=1. `pulse_ui` is registered high for one cycle when `presc` wraps.
- `frame_ui_cnt` advances by 1 on each `pulse_ui` cycle, wrapping FRAME_UI-1 → 0.
- `ch_sof[i]` is high in the same cycle as the `pulse_ui` that moves `frame_ui_cnt` to i*STAGGER_UI. `ch_sof[0]` marks the frame start.
- `run`=0: `presc`←0 and `frame_ui_cnt`←FRAME_UI-1 synchronously. No `pulse_ui` or `ch_sof` is produced. Active and shadow registers hold.
- Width write: `wr_en` with `wr_addr`<NUM_CH stores the clamped data in `shadow_w[wr_addr]` and sets `pend_w[wr_addr]`.
  - Clamp: 0 stays 0; 1..MIN_UI-1 → MIN_UI; >MAX_UI → MAX_UI.
  - An out-of-range address changes no state.
- Enable write: `en_wr` stores `en_data` in `shadow_en` and sets `pend_en`.
- Commit: occurs on the `pulse_ui` that moves `frame_ui_cnt` to FRAME_UI-1, i.e. one UI before `ch_sof[0]`.
  - Every pending width copies to its active register. `shadow_en` copies to `ch_en` if `pend_en` is set.
  - All pend flags clear. `commit_stb` pulses whether or not anything was pending.
- Simultaneous write and commit: commit uses the pre-write shadow value. The new write lands in shadow and stays pending until the next commit.
- Simultaneous `wr_en` and `en_wr` are both accepted.

## Timing
- Reset values:
  - `pulse_ui`, `ch_sof`, `ch_en`, `ch_pulse_width_ui`, `wr_ack`, `wr_err`, `commit_stb` = 0.
  - Shadows and pend flags = 0; `presc`=0; `frame_ui_cnt`=FRAME_UI-1.
- After `run` rises, the first `pulse_ui` and `ch_sof[0]` occur together CLKS_PER_UI cycles later. The first frame uses active values (reset: all 0, no pulses). The first commit occurs FRAME_UI-1 UIs after that.
- `wr_ack` / `wr_err` assert exactly one cycle after the strobe. Every strobe is accepted; there is no backpressure.
- Committed outputs change the cycle after the commit tick. They are stable for ≥CLKS_PER_UI-1 cycles before `ch_sof[0]`, and stable for the whole frame.
- `rst` mid-frame clears everything immediately, including pending writes. Operation restarts as if from power-up.
- `run` dropping mid-frame restarts the frame. No commit happens until a full frame elapses.

## Test plan
Use NUM_CH=4, CLKS_PER_UI=4, FRAME_UI=40, STAGGER_UI=5, MIN_UI=2, MAX_UI=20.
- Timebase: release `rst`, then `run`=1 → `pulse_ui` every 4 cycles. `ch_sof[0..3]` appear at UI 0, 5, 10, 15. `frame_ui_cnt` wraps 39→0. `commit_stb` fires on entry to UI 39.
- Clamp/commit:
  - Write ch2 with 1 → `ch_pulse_width_ui[ch2]`=2 only after the next commit.
  - Write ch1 with 4000 → 20. Write ch0 with 0 → 0.
  - Write address 5 → `wr_err`=1 and no state change.
- Write coincident with the commit cycle (ch3 = 7) → the commit takes the old ch3 shadow. ch3 = 7 appears one frame later.
- Enable mask 4'b1010 written mid-frame → `ch_en` unchanged until the commit, then 4'b1010.
- Async `rst` asserted mid-frame with pending writes → all outputs 0 immediately. After release and `run`, the first frame has widths 0.
- `run` dropped at UI 20 → no ticks; `frame_ui_cnt`=39. On re-assert, `ch_sof[0]` occurs 4 cycles later with no commit in between.

Source files
------------

// File: rtl/servo_pwm_sched.sv
// Frame timebase, staggered per-channel start-of-frame strobes and shadow/active
// configuration registers for a bank of servo PWM channels.
module servo_pwm_sched #(
    parameter int NUM_CH      = 8,
    parameter int CLKS_PER_UI = 100,
    parameter int FRAME_UI    = 20000,
    parameter int STAGGER_UI  = 250,
    parameter int MIN_UI      = 500,
    parameter int MAX_UI      = 2500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [11:0]          wr_data,
    input  logic                 en_wr,
    input  logic [NUM_CH-1:0]    en_data,
    output logic                 pulse_ui,
    output logic [NUM_CH-1:0]    ch_sof,
    output logic [NUM_CH-1:0]    ch_en,
    output logic [12*NUM_CH-1:0] ch_pulse_width_ui,
    output logic                 wr_ack,
    output logic                 wr_err,
    output logic                 commit_stb,
    output logic [14:0]          frame_ui_cnt
);

    localparam int              PW         = (CLKS_PER_UI > 1) ? $clog2(CLKS_PER_UI) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKS_PER_UI - 1);
    localparam logic [14:0]     FRAME_LAST = 15'(FRAME_UI - 1);
    localparam logic [11:0]     MIN_W      = 12'(MIN_UI);
    localparam logic [11:0]     MAX_W      = 12'(MAX_UI);

    logic [PW-1:0]     presc;
    logic              wrap;
    logic [14:0]       frame_next;
    logic              commit;
    logic [NUM_CH-1:0] sof_next;
    logic              addr_ok;
    logic [NUM_CH-1:0] wr_sel;

    logic [11:0]       shadow_w [NUM_CH];
    logic [11:0]       act_w    [NUM_CH];
    logic [NUM_CH-1:0] pend_w;
    logic [NUM_CH-1:0] shadow_en;
    logic              pend_en;

    function automatic logic [11:0] clamp_width(input logic [11:0] d);
        if (d == 12'd0)
            return 12'd0;
        else if (d < MIN_W)
            return MIN_W;
        else if (d > MAX_W)
            return MAX_W;
        else
            return d;
    endfunction

    assign wrap       = run && (presc == PRESC_LAST);
    assign frame_next = (frame_ui_cnt == FRAME_LAST) ? 15'd0 : frame_ui_cnt + 15'd1;
    // Commit lands one UI ahead of channel 0's SOF so every channel starts its frame on fresh values.
    assign commit     = wrap && (frame_next == FRAME_LAST);
    assign addr_ok    = ({1'b0, wr_addr} < 5'(NUM_CH));

    always_comb begin
        sof_next = '0;
        wr_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sof_next[i] = wrap && (frame_next == 15'(i * STAGGER_UI));
            wr_sel[i]   = wr_en && addr_ok && (wr_addr == 4'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            frame_ui_cnt <= FRAME_LAST;
            pulse_ui     <= 1'b0;
            ch_sof       <= '0;
            commit_stb   <= 1'b0;
        end else if (!run) begin
            presc        <= '0;
            frame_ui_cnt <= FRAME_LAST;
            pulse_ui     <= 1'b0;
            ch_sof       <= '0;
            commit_stb   <= 1'b0;
        end else begin
            presc      <= wrap ? '0 : presc + PW'(1);
            pulse_ui   <= wrap;
            ch_sof     <= sof_next;
            commit_stb <= commit;
            if (wrap)
                frame_ui_cnt <= frame_next;
        end
    end

    // Enable-mask writes are always accepted, so they acknowledge on wr_ack as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= (wr_en && addr_ok) || en_wr;
            wr_err <= wr_en && !addr_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                shadow_w[i] <= '0;
            shadow_en <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (wr_sel[i])
                    shadow_w[i] <= clamp_width(wr_data);
            if (en_wr)
                shadow_en <= en_data;
        end
    end

    // A write coinciding with the commit stays pending: the new set overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_w  <= '0;
            pend_en <= 1'b0;
        end else begin
            pend_w  <= (commit ? '0 : pend_w) | wr_sel;
            pend_en <= (pend_en && !commit) || en_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                act_w[i] <= '0;
            ch_en <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_CH; i++)
                if (pend_w[i])
                    act_w[i] <= shadow_w[i];
            if (pend_en)
                ch_en <= shadow_en;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pack
        assign ch_pulse_width_ui[12*gi +: 12] = act_w[gi];
    end

endmodule

// File: tb/tb_servo_pwm_sched.sv
// Directed and randomized checks of servo_pwm_sched against a frame-arithmetic
// reference model (UI and frame position derived from cycles elapsed since run rose).
module tb_servo_pwm_sched;

    localparam int NUM_CH = 4;
    localparam int CPU    = 4;
    localparam int FRAME  = 40;
    localparam int STAG   = 5;
    localparam int MINW   = 2;
    localparam int MAXW   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        en_wr;
    logic [3:0]  en_data;
    logic        pulse_ui;
    logic [3:0]  ch_sof;
    logic [3:0]  ch_en;
    logic [47:0] ch_pulse_width_ui;
    logic        wr_ack;
    logic        wr_err;
    logic        commit_stb;
    logic [14:0] frame_ui_cnt;

    servo_pwm_sched #(
        .NUM_CH(NUM_CH), .CLKS_PER_UI(CPU), .FRAME_UI(FRAME),
        .STAGGER_UI(STAG), .MIN_UI(MINW), .MAX_UI(MAXW)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .en_wr(en_wr), .en_data(en_data),
        .pulse_ui(pulse_ui), .ch_sof(ch_sof), .ch_en(ch_en),
        .ch_pulse_width_ui(ch_pulse_width_ui), .wr_ack(wr_ack), .wr_err(wr_err),
        .commit_stb(commit_stb), .frame_ui_cnt(frame_ui_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int         m_shadow_w [NUM_CH];
    int         m_act_w    [NUM_CH];
    bit         m_pend_w   [NUM_CH];
    logic [3:0] m_shadow_en, m_act_en;
    bit         m_pend_en;
    int         run_cycles;
    bit         run_lvl;
    logic       exp_pulse, exp_commit, exp_ack, exp_err;
    logic [3:0] exp_sof;

    function automatic int clampRef(input int d);
        if (d == 0) return 0;
        if (d < MINW) return MINW;
        if (d > MAXW) return MAXW;
        return d;
    endfunction

    // Frame position follows directly from how many run-cycles have elapsed.
    function automatic int framePos(input int rc);
        return (rc / CPU + FRAME - 1) % FRAME;
    endfunction

    function automatic bit nextIsCommit();
        return run_lvl && ((run_cycles + 1) % CPU == 0) && (framePos(run_cycles + 1) == FRAME - 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic timeoutFail(input string tag);
        total++;
        $error("[TB] FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow_w[i] = 0;
            m_act_w[i]    = 0;
            m_pend_w[i]   = 1'b0;
        end
        m_shadow_en = '0;
        m_act_en    = '0;
        m_pend_en   = 1'b0;
        run_cycles  = 0;
        exp_pulse   = 1'b0;
        exp_commit  = 1'b0;
        exp_ack     = 1'b0;
        exp_err     = 1'b0;
        exp_sof     = '0;
    endtask

    task automatic modelEdge(input bit r, input bit we, input logic [3:0] a, input logic [11:0] d,
                             input bit ew, input logic [3:0] ed);
        int pos;
        exp_pulse  = 1'b0;
        exp_commit = 1'b0;
        exp_sof    = '0;
        if (!r) begin
            run_cycles = 0;
        end else begin
            run_cycles++;
            if (run_cycles % CPU == 0) begin
                exp_pulse = 1'b1;
                pos = framePos(run_cycles);
                for (int i = 0; i < NUM_CH; i++)
                    if (pos == i * STAG) exp_sof[i] = 1'b1;
                if (pos == FRAME - 1) begin
                    exp_commit = 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (m_pend_w[i]) m_act_w[i] = m_shadow_w[i];
                        m_pend_w[i] = 1'b0;
                    end
                    if (m_pend_en) m_act_en = m_shadow_en;
                    m_pend_en = 1'b0;
                end
            end
        end
        exp_ack = (we && a < NUM_CH) || ew;
        exp_err = we && a >= NUM_CH;
        if (we && a < NUM_CH) begin
            m_shadow_w[a] = clampRef(int'(d));
            m_pend_w[a]   = 1'b1;
        end
        if (ew) begin
            m_shadow_en = ed;
            m_pend_en   = 1'b1;
        end
    endtask

    task automatic checkAll();
        logic [47:0] ew;
        for (int i = 0; i < NUM_CH; i++) ew[12*i +: 12] = 12'(m_act_w[i]);
        checkOutput("pulse_ui",     64'(pulse_ui),          64'(exp_pulse));
        checkOutput("ch_sof",       64'(ch_sof),            64'(exp_sof));
        checkOutput("commit_stb",   64'(commit_stb),        64'(exp_commit));
        checkOutput("frame_ui_cnt", 64'(frame_ui_cnt),      64'(framePos(run_cycles)));
        checkOutput("ch_en",        64'(ch_en),             64'(m_act_en));
        checkOutput("widths",       64'(ch_pulse_width_ui), 64'(ew));
        checkOutput("wr_ack",       64'(wr_ack),            64'(exp_ack));
        checkOutput("wr_err",       64'(wr_err),            64'(exp_err));
    endtask

    task automatic applyStimulus(input bit r, input bit we, input int a, input int d,
                                 input bit ew, input logic [3:0] ed);
        run     = r;
        run_lvl = r;
        wr_en   = we;
        wr_addr = 4'(a);
        wr_data = 12'(d);
        en_wr   = ew;
        en_data = ed;
        @(posedge clk);
        #1;
        modelEdge(r, we, 4'(a), 12'(d), ew, ed);
        checkAll();
        wr_en = 1'b0;
        en_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(run_lvl, 1'b0, 0, 0, 1'b0, 4'd0);
    endtask

    task automatic runToCommit(input string tag);
        int guard = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 4'd0);
            guard++;
        end while (!exp_commit && guard < 400);
        if (!exp_commit) timeoutFail(tag);
    endtask

    initial begin
        int guard;
        rst = 1'b1; run = 1'b0; run_lvl = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; en_wr = 1'b0; en_data = '0;
        modelReset();
        #12;
        checkAll();
        rst = 1'b0;

        $display("[TB] timebase");
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 4'd0);
        for (int i = 0; i < CPU; i++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 4'd0);
        checkOutput("first_sof", 64'(ch_sof), 64'd1);
        runToCommit("first_commit");
        checkOutput("first_commit_frame", 64'(frame_ui_cnt), 64'(FRAME - 1));

        $display("[TB] clamp and commit");
        applyStimulus(1'b1, 1'b1, 2, 1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1, 4000, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 0, 0, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 3, 9, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 5, 13, 1'b0, 4'd0);
        checkOutput("bad_addr_err", 64'(wr_err), 64'd1);
        checkOutput("pre_commit_widths", 64'(ch_pulse_width_ui), 64'd0);
        runToCommit("clamp_commit");
        checkOutput("clamped_widths", 64'(ch_pulse_width_ui), {16'd0, 12'd9, 12'd2, 12'd20, 12'd0});

        $display("[TB] write coincident with commit");
        guard = 0;
        while (!nextIsCommit() && guard < 400) begin
            idle(1);
            guard++;
        end
        if (!nextIsCommit()) timeoutFail("reach_commit");
        applyStimulus(1'b1, 1'b1, 3, 7, 1'b0, 4'd0);
        checkOutput("coincident_old_ch3", 64'(ch_pulse_width_ui[47:36]), 64'd9);
        runToCommit("coincident_next");
        checkOutput("coincident_new_ch3", 64'(ch_pulse_width_ui[47:36]), 64'd7);

        $display("[TB] enable mask");
        idle(80);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 4'b1010);
        idle(1);
        checkOutput("en_before_commit", 64'(ch_en), 64'd0);
        runToCommit("en_commit");
        checkOutput("en_after_commit", 64'(ch_en), 64'b1010);

        $display("[TB] async reset");
        idle(30);
        applyStimulus(1'b1, 1'b1, 0, 15, 1'b1, 4'b0101);
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #2;
        checkAll();
        rst = 1'b0;
        runToCommit("post_reset_commit");
        checkOutput("post_reset_widths", 64'(ch_pulse_width_ui), 64'd0);
        checkOutput("post_reset_en", 64'(ch_en), 64'd0);

        $display("[TB] run drop");
        guard = 0;
        while (!(exp_pulse && framePos(run_cycles) == 20) && guard < 400) begin
            idle(1);
            guard++;
        end
        if (!exp_pulse) timeoutFail("reach_ui20");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 4'd0);
        checkOutput("held_frame", 64'(frame_ui_cnt), 64'(FRAME - 1));
        checkOutput("held_pulse", 64'(pulse_ui), 64'd0);
        for (int i = 0; i < CPU; i++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 4'd0);
        checkOutput("restart_sof0", 64'(ch_sof), 64'd1);
        checkOutput("restart_no_commit", 64'(commit_stb), 64'd0);

        $display("[TB] random");
        for (int n = 0; n < 1200; n++) begin
            bit r, we, ew;
            int a, d;
            r  = ($urandom_range(0, 199) != 0);
            we = ($urandom_range(0, 3) == 0);
            ew = ($urandom_range(0, 7) == 0);
            a  = $urandom_range(0, 7);
            case ($urandom_range(0, 4))
                0:       d = 0;
                1:       d = 1;
                2:       d = $urandom_range(0, 4095);
                3:       d = $urandom_range(MAXW, MAXW + 1);
                default: d = $urandom_range(0, 25);
            endcase
            applyStimulus(r, we, a, d, ew, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
